// File: rtl/cu_pkg.sv
// rtl/cu_pkg.sv - opcode constants, control enums and decode helpers for pipe_cu
// Shared by ctrl_decode and pipe_cu. It holds no ports.
package cu_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b100,
        ALU_SLL = 3'b101,
        ALU_SRL = 3'b110,
        ALU_XOR = 3'b111
    } alu_ctrl_t;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100
    } imm_src_t;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10,
        RES_IMM = 2'b11
    } result_src_t;

    // Controls carried by ID/EX. An all-zero value is a bubble: it writes
    // nothing and can never redirect the PC.
    typedef struct packed {
        logic        reg_write;
        result_src_t result_src;
        logic        mem_write;
        logic        jump;
        logic        branch;
        logic        funct3_0;   // 0 = beq, 1 = bne
        alu_ctrl_t   alu_ctrl;
        logic        alu_src;
        logic        jump_src;
    } ex_ctrl_t;

    // funct3 to ALU op, shared by R-type and I-ALU. funct3 011 has no
    // supported op and falls back to ADD.
    function automatic alu_ctrl_t alu_from_funct3(input logic [2:0] funct3);
        case (funct3)
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b100:  return ALU_XOR;
            3'b101:  return ALU_SRL;
            3'b110:  return ALU_OR;
            3'b111:  return ALU_AND;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/pipe_cu_if.sv
// rtl/pipe_cu_if.sv - control-unit signal bundle between the datapath and pipe_cu
// master: datapath/bench side. It drives instr_d, eq_e and flush_e and reads all controls.
// slave:  pipe_cu side.
interface pipe_cu_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] instr_d;
    logic             eq_e;
    logic             flush_e;
    logic [2:0]       imm_src_d;
    logic             illegal_d;
    logic [2:0]       alu_ctrl_e;
    logic             alu_src_e;
    logic [1:0]       result_src_e;
    logic             pc_src_e;
    logic             jump_src_e;
    logic             mem_write_m;
    logic             reg_write_m;
    logic             reg_write_w;
    logic [1:0]       result_src_w;

    modport master (
        output instr_d, eq_e, flush_e,
        input  imm_src_d, illegal_d, alu_ctrl_e, alu_src_e, result_src_e,
               pc_src_e, jump_src_e, mem_write_m, reg_write_m,
               reg_write_w, result_src_w
    );

    modport slave (
        input  instr_d, eq_e, flush_e,
        output imm_src_d, illegal_d, alu_ctrl_e, alu_src_e, result_src_e,
               pc_src_e, jump_src_e, mem_write_m, reg_write_m,
               reg_write_w, result_src_w
    );
endinterface

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - combinational instruction decode into pipeline controls
// opcode/funct3/bit30 : decode-stage instruction fields
// ctrl                : controls loaded into ID/EX (all zero for unsupported opcodes)
// imm_src             : immediate format for the decode stage
// illegal             : opcode is unsupported
module ctrl_decode
    import cu_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       bit30,
    output ex_ctrl_t   ctrl,
    output imm_src_t   imm_src,
    output logic       illegal
);

    always_comb begin
        ctrl    = '0;
        imm_src = IMM_I;
        illegal = 1'b0;
        case (opcode)
            OP_R: begin
                ctrl.reg_write = 1'b1;
                // Only funct3 000 has a subtract form; bit30 is ignored
                // elsewhere, so 101 always decodes as SRL.
                ctrl.alu_ctrl  = (funct3 == 3'b000 && bit30) ? ALU_SUB
                                                             : alu_from_funct3(funct3);
            end
            OP_I: begin
                // bit30 is immediate data here, so funct3 000 is always ADD.
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_ctrl  = alu_from_funct3(funct3);
            end
            OP_LOAD: begin
                ctrl.reg_write  = 1'b1;
                ctrl.result_src = RES_MEM;
                ctrl.alu_src    = 1'b1;
            end
            OP_STORE: begin
                ctrl.mem_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                imm_src        = IMM_S;
            end
            OP_BRANCH: begin
                ctrl.branch   = 1'b1;
                ctrl.funct3_0 = funct3[0];
                ctrl.alu_ctrl = ALU_SUB;
                imm_src       = IMM_B;
            end
            OP_JAL: begin
                ctrl.jump       = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.result_src = RES_PC4;
                imm_src         = IMM_J;
            end
            OP_JALR: begin
                ctrl.jump       = 1'b1;
                ctrl.jump_src   = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.result_src = RES_PC4;
                ctrl.alu_src    = 1'b1;
            end
            OP_LUI: begin
                ctrl.reg_write  = 1'b1;
                ctrl.result_src = RES_IMM;
                imm_src         = IMM_U;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/pipe_cu.sv
// rtl/pipe_cu.sv - pipelined control unit: ID/EX, EX/MEM, MEM/WB control registers and branch resolve
// clk, rst : rising-edge clock and synchronous active-high reset
// bus      : pipe_cu_if slave. Decode-stage instruction, execute-stage eq_e and flush_e in;
//            decode, execute, memory and writeback controls out.
// WIDTH    : instruction width; must be at least 32.
module pipe_cu
    import cu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic      clk,
    input  logic      rst,
    pipe_cu_if.slave  bus
);

    ex_ctrl_t dec_ctrl;
    imm_src_t dec_imm_src;
    logic     dec_illegal;

    ex_ctrl_t id_ex;
    logic     ex_mem_reg_write;
    logic     ex_mem_mem_write;
    logic [1:0] ex_mem_result_src;
    logic     mem_wb_reg_write;
    logic [1:0] mem_wb_result_src;

    logic     pc_src;

    // Decode looks only at opcode, funct3 and bit30.
    logic unused_instr_bits;
    assign unused_instr_bits = ^{bus.instr_d[WIDTH-1:31], bus.instr_d[29:15],
                                 bus.instr_d[11:7]};

    ctrl_decode u_decode (
        .opcode  (bus.instr_d[6:0]),
        .funct3  (bus.instr_d[14:12]),
        .bit30   (bus.instr_d[30]),
        .ctrl    (dec_ctrl),
        .imm_src (dec_imm_src),
        .illegal (dec_illegal)
    );

    // A bubble has jump and branch clear, so it can never redirect.
    assign pc_src = id_ex.jump | (id_ex.branch & (bus.eq_e ^ id_ex.funct3_0));

    always_ff @(posedge clk) begin
        if (rst) begin
            id_ex             <= '0;
            ex_mem_reg_write  <= 1'b0;
            ex_mem_mem_write  <= 1'b0;
            ex_mem_result_src <= 2'b00;
            mem_wb_reg_write  <= 1'b0;
            mem_wb_result_src <= 2'b00;
        end else begin
            // A redirect squashes the wrong-path instruction in decode.
            // flush_e together with a redirect still gives a single bubble.
            if (bus.flush_e || pc_src) begin
                id_ex <= '0;
            end else begin
                id_ex <= dec_ctrl;
            end
            ex_mem_reg_write  <= id_ex.reg_write;
            ex_mem_mem_write  <= id_ex.mem_write;
            ex_mem_result_src <= id_ex.result_src;
            mem_wb_reg_write  <= ex_mem_reg_write;
            mem_wb_result_src <= ex_mem_result_src;
        end
    end

    assign bus.imm_src_d    = dec_imm_src;
    assign bus.illegal_d    = dec_illegal;
    assign bus.alu_ctrl_e   = id_ex.alu_ctrl;
    assign bus.alu_src_e    = id_ex.alu_src;
    assign bus.result_src_e = id_ex.result_src;
    assign bus.pc_src_e     = pc_src;
    assign bus.jump_src_e   = id_ex.jump_src;
    assign bus.mem_write_m  = ex_mem_mem_write;
    assign bus.reg_write_m  = ex_mem_reg_write;
    assign bus.reg_write_w  = mem_wb_reg_write;
    assign bus.result_src_w = mem_wb_result_src;

endmodule
